// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - shared AHB encodings and field widths for the bus matrix
package ahb_mtx_pkg;

  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;
  localparam int PROT_W  = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_xfer(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_hold_reg.sv
// rtl/ahb_mtx_hold_reg.sv - held address-phase register bank with live/held output mux
module ahb_mtx_hold_reg
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                load,
  input  logic                pend,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [1:0]          trans,
  input  logic                write,
  input  logic [SIZE_W-1:0]   size,
  input  logic [BURST_W-1:0]  burst,
  input  logic [PROT_W-1:0]   prot,
  input  logic                mastlock,
  output logic [ADDR_W-1:0]   mux_addr,
  output logic [1:0]          mux_trans,
  output logic                mux_write,
  output logic [SIZE_W-1:0]   mux_size,
  output logic [BURST_W-1:0]  mux_burst,
  output logic [PROT_W-1:0]   mux_prot,
  output logic                mux_mastlock
);

  logic [ADDR_W-1:0]  held_addr;
  logic [1:0]         held_trans;
  logic               held_write;
  logic [SIZE_W-1:0]  held_size;
  logic [BURST_W-1:0] held_burst;
  logic [PROT_W-1:0]  held_prot;
  logic               held_mastlock;

  // Capture the stalled address phase only on the cycle it is refused.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_addr     <= '0;
      held_trans    <= '0;
      held_write    <= 1'b0;
      held_size     <= '0;
      held_burst    <= '0;
      held_prot     <= '0;
      held_mastlock <= 1'b0;
    end else if (load) begin
      held_addr     <= addr;
      held_trans    <= trans;
      held_write    <= write;
      held_size     <= size;
      held_burst    <= burst;
      held_prot     <= prot;
      held_mastlock <= mastlock;
    end
  end

  // While pending the arbiters must see the captured transfer, not the master's current bus.
  always_comb begin
    mux_addr     = pend ? held_addr     : addr;
    mux_trans    = pend ? held_trans    : trans;
    mux_write    = pend ? held_write    : write;
    mux_size     = pend ? held_size     : size;
    mux_burst    = pend ? held_burst    : burst;
    mux_prot     = pend ? held_prot     : prot;
    mux_mastlock = pend ? held_mastlock : mastlock;
  end

endmodule

// File: rtl/ahb_mtx_input_hold_stage.sv
// rtl/ahb_mtx_input_hold_stage.sv - per-master input hold stage; AHB_MTX_WAIT_CNT_EN adds wait_cnt_o
module ahb_mtx_input_hold_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELS,
  input  logic [ADDR_W-1:0]   HADDRS,
  input  logic [1:0]          HTRANSS,
  input  logic                HWRITES,
  input  logic [SIZE_W-1:0]   HSIZES,
  input  logic [BURST_W-1:0]  HBURSTS,
  input  logic [PROT_W-1:0]   HPROTS,
  input  logic                HMASTLOCKS,
  input  logic                HREADYS,
  input  logic                active_in,
  input  logic                readyout_in,
  input  logic [1:0]          resp_in,
  output logic                HREADYOUTS,
  output logic [1:0]          HRESPS,
  output logic                req_o,
  output logic                sel_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [1:0]          trans_o,
  output logic                write_o,
  output logic [SIZE_W-1:0]   size_o,
  output logic [BURST_W-1:0]  burst_o,
  output logic [PROT_W-1:0]   prot_o,
  output logic                mastlock_o
`ifdef AHB_MTX_WAIT_CNT_EN
  ,
  output logic [15:0]         wait_cnt_o
`endif
);

  logic pend;
  logic data_phase;
  logic new_tran;
  logic load;
  logic accept;

  assign new_tran = HSELS & HREADYS & is_xfer(HTRANSS);
  assign load     = ~pend & new_tran & ~active_in;
  assign accept   = active_in & (pend | new_tran);

  // Pending flag: set when a new transfer is refused, cleared when the arbiter finally takes it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= 1'b0;
    end else if (load) begin
      pend <= 1'b1;
    end else if (pend && active_in) begin
      pend <= 1'b0;
    end
  end

  // Data phase tracks an accepted address until the granted port signals completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_phase <= 1'b0;
    end else if (accept) begin
      data_phase <= 1'b1;
    end else if (data_phase && readyout_in) begin
      data_phase <= 1'b0;
    end
  end

  ahb_mtx_hold_reg #(
    .ADDR_W(ADDR_W)
  ) u_hold (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .load         (load),
    .pend         (pend),
    .addr         (HADDRS),
    .trans        (HTRANSS),
    .write        (HWRITES),
    .size         (HSIZES),
    .burst        (HBURSTS),
    .prot         (HPROTS),
    .mastlock     (HMASTLOCKS),
    .mux_addr     (addr_o),
    .mux_trans    (trans_o),
    .mux_write    (write_o),
    .mux_size     (size_o),
    .mux_burst    (burst_o),
    .mux_prot     (prot_o),
    .mux_mastlock (mastlock_o)
  );

  // Master-facing handshake: stall while pending, else mirror the granted port's data phase.
  always_comb begin
    req_o  = pend | new_tran;
    sel_o  = pend | (HSELS & HREADYS);
    HRESPS = data_phase ? resp_in : HRESP_OKAY;
    if (pend) begin
      HREADYOUTS = 1'b0;
    end else if (data_phase) begin
      HREADYOUTS = readyout_in;
    end else begin
      HREADYOUTS = 1'b1;
    end
  end

`ifdef AHB_MTX_WAIT_CNT_EN
  logic [15:0] wait_cnt;

  // Counts stall cycles of the current pending transfer, saturating, cleared on grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (pend && active_in) begin
      wait_cnt <= '0;
    end else if (pend && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign wait_cnt_o = wait_cnt;
`endif

endmodule

// File: doc/ahb_mtx_input_hold_stage.md
Name: ahb_mtx_input_hold_stage

Overview:
- Per-master input stage of the AHB bus matrix; sits upstream of the per-slave output arbiters.
- Registers the address-phase signals of a transfer that the targeted output port cannot accept this cycle.
- Stalls the master with HREADYOUTS low until the arbiter grants the transfer.
- Presents either live or held address/control plus a request flag to the decoder and output arbiters.

Parameters:
ADDR_W, 32, address width.

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  asynchronous active-low reset
HSELS  in  1  master-side select
HADDRS  in  ADDR_W  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  write flag
HSIZES  in  3  transfer size
HBURSTS  in  3  burst type
HPROTS  in  4  protection
HMASTLOCKS  in  1  locked transfer
HREADYS  in  1  bus HREADY seen by master
active_in  in  1  granting output port accepts this port's address this cycle (selected, not no_port, HREADYM=1)
readyout_in  in  1  data-phase HREADY from granted output port
resp_in  in  2  data-phase HRESP from granted output port
HREADYOUTS  out  1  ready to master
HRESPS  out  2  response to master
req_o  out  1  transfer request to decoder/arbiters
sel_o  out  1  HSEL toward arbiter (keeps port on IDLE)
addr_o  out  ADDR_W  muxed address
trans_o  out  2  muxed HTRANS
write_o  out  1  muxed write flag
size_o  out  3  muxed size
burst_o  out  3  muxed burst type
prot_o  out  4  muxed protection
mastlock_o  out  1  muxed lock

Behaviour:
- Reset: pend=0, data_phase=0, all held registers 0.
  - HREADYOUTS=1, HRESPS=OKAY (2'b00), req_o=0, sel_o=0.
- new_tran = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
- States: IDLE (pend=0), PEND (pend=1). data_phase is an orthogonal flag.
  - IDLE→PEND on new_tran & ~active_in. At that edge, capture HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS and HMASTLOCKS.
  - PEND→IDLE on active_in. Held registers are untouched.
  - PEND with ~active_in: stay in PEND; no recapture.
- Mux: pend ? held : live, for addr_o, trans_o, write_o, size_o, burst_o, prot_o, mastlock_o.
- req_o = pend | new_tran.
- sel_o = pend | (HSELS & HREADYS).
- data_phase:
  - Next value is 1 when an address is accepted: active_in & (pend | new_tran).
  - Otherwise next value is 0 if readyout_in=1 while data_phase=1.
  - Otherwise data_phase holds.
- PEND can only be entered when the previous data phase has completed, because new_tran requires HREADYS=1. data_phase is therefore 0 whenever PEND is entered.
- HREADYOUTS:
  - pend=1 → 0.
  - data_phase=1 → readyout_in.
  - Otherwise 1 (zero-wait).
- HRESPS = data_phase ? resp_in : OKAY. A two-cycle ERROR is passed through unmodified.
- Zero-latency path: new_tran & active_in in the same cycle gives no stall; PEND is never entered.
- IDLE/BUSY with HSELS=1: no request, HREADYOUTS=1, OKAY.
- Reset mid-PEND: the held transfer is discarded; outputs return to reset values asynchronously.

Optional Feature:
AHB_MTX_WAIT_CNT_EN
- Defined: adds output wait_cnt_o [15:0].
  - Increments each cycle pend=1 and saturates at 16'hFFFF.
  - Clears to 0 when the PEND→IDLE transition occurs.
  - Reset value 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ahb_mtx_pkg:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST encodings.
  - HRESP OKAY/ERROR.
  - Field widths for size (3), burst (3) and prot (4).
- Optional sub-module ahb_mtx_hold_reg: enable-loaded register bank plus output mux, parameterised by ADDR_W. The top module keeps the pend/data_phase control.

Test Plan:
- Transfer granted immediately:
  - Stimulus: NONSEQ addr 0x2000_0010, active_in=1 the same cycle.
  - Response: req_o=1, pend stays 0, HREADYOUTS=1; next cycle data_phase=1 and HREADYOUTS follows readyout_in.
- Transfer held then granted:
  - Stimulus: NONSEQ write addr 0x2000_0040 with active_in=0 for 3 cycles, then 1.
  - Response: HREADYOUTS=0 for 3 cycles; addr_o stays 0x2000_0040 even when HADDRS changes to 0x0; one cycle after the grant, pend=0 and data_phase=1.
- Error response pass-through:
  - Stimulus: resp_in=ERROR with readyout_in=0 then 1.
  - Response: HRESPS=ERROR both cycles; HREADYOUTS = 0 then 1; data_phase clears after the second cycle.
- IDLE with select held:
  - Stimulus: HSELS=1, HTRANSS=IDLE.
  - Response: req_o=0, sel_o=1, HREADYOUTS=1, HRESPS=OKAY.
- Reset while pending:
  - Stimulus: assert HRESETn=0 while pend=1.
  - Response: immediate req_o=0, HREADYOUTS=1, addr_o = live HADDRS.
- Wait counter (AHB_MTX_WAIT_CNT_EN defined):
  - Stimulus: 5 stall cycles, then a grant.
  - Response: wait_cnt_o reads 5 before the grant and 0 after it.
